// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the main-memory arbiter: FSM states, grant ids and counter width.
package mem_arbiter_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter that times the memory access window of the arbiter.
module mem_arb_timer
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_f,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
    assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port main memory between instruction fetch and the LOD/STR data path.
// Handshake: a requester holds req and its inputs stable until its done pulse; done is one cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter bit DATA_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output state_t            o_dbg_state
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);

    state_t            r_state, w_state_n;
    gnt_t              r_gnt, w_gnt_n, r_last_grant, w_last_grant_n, w_gnt_sel;
    logic              r_mem_en, w_mem_en_n, r_mem_we, w_mem_we_n;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_n;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_n;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata_n, r_d_rdata, w_d_rdata_n;
    logic              r_if_done, w_if_done_n, r_d_done, w_d_done_n;
    logic              r_busy, w_busy_n;
    logic              w_any_req, w_tmr_load, w_tmr_dec, w_cnt_zero, w_cnt_last;

    assign w_any_req = if_req | d_req;
    assign w_tmr_dec = (r_state == ST_ACCESS) && !w_cnt_zero;

    mem_arb_timer u_timer (
        .clk        (clk),
        .rst_f      (rst_f),
        .i_load     (w_tmr_load),
        .i_load_val (LAT_CNT),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_cnt_zero),
        .o_last     (w_cnt_last)
    );

    // On contention the port that did not win last time is chosen, unless data has priority.
    always_comb begin
        w_gnt_sel = GNT_IF;
        if (d_req && (!if_req || DATA_PRIO || (r_last_grant == GNT_IF))) begin
            w_gnt_sel = GNT_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            r_state      <= ST_IDLE;
            r_gnt        <= GNT_IF;
            r_last_grant <= GNT_D;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_if_done    <= 1'b0;
            r_d_done     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_gnt        <= w_gnt_n;
            r_last_grant <= w_last_grant_n;
            r_mem_en     <= w_mem_en_n;
            r_mem_we     <= w_mem_we_n;
            r_mem_addr   <= w_mem_addr_n;
            r_mem_wdata  <= w_mem_wdata_n;
            r_if_rdata   <= w_if_rdata_n;
            r_d_rdata    <= w_d_rdata_n;
            r_if_done    <= w_if_done_n;
            r_d_done     <= w_d_done_n;
            r_busy       <= w_busy_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_any_req) w_state_n = ST_ACCESS;
            ST_ACCESS: if (w_cnt_last) w_state_n = ST_DONE;
            ST_DONE:   w_state_n = ST_IDLE;
            default:   w_state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_n        = r_gnt;
        w_last_grant_n = r_last_grant;
        w_mem_en_n     = r_mem_en;
        w_mem_we_n     = r_mem_we;
        w_mem_addr_n   = r_mem_addr;
        w_mem_wdata_n  = r_mem_wdata;
        w_if_rdata_n   = r_if_rdata;
        w_d_rdata_n    = r_d_rdata;
        w_if_done_n    = 1'b0;
        w_d_done_n     = 1'b0;
        w_busy_n       = r_busy;
        w_tmr_load     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_busy_n = 1'b0;
                if (w_any_req) begin
                    w_gnt_n        = w_gnt_sel;
                    w_last_grant_n = w_gnt_sel;
                    w_mem_en_n     = 1'b1;
                    w_busy_n       = 1'b1;
                    w_tmr_load     = 1'b1;
                    if (w_gnt_sel == GNT_D) begin
                        w_mem_we_n    = d_we;
                        w_mem_addr_n  = d_addr;
                        w_mem_wdata_n = d_wdata;
                    end else begin
                        w_mem_we_n   = 1'b0;
                        w_mem_addr_n = if_addr;
                    end
                end
            end
            ST_ACCESS: begin
                if (w_cnt_last) begin
                    w_mem_en_n = 1'b0;
                    w_mem_we_n = 1'b0;
                    if (r_gnt == GNT_D) begin
                        w_d_done_n = 1'b1;
                        // Stores complete without touching the load-data register.
                        if (!r_mem_we) w_d_rdata_n = mem_rdata;
                    end else begin
                        w_if_done_n  = 1'b1;
                        w_if_rdata_n = mem_rdata;
                    end
                end
            end
            ST_DONE: w_busy_n = 1'b0;
            default: w_busy_n = 1'b0;
        endcase
    end

    assign if_done     = r_if_done;
    assign if_rdata    = r_if_rdata;
    assign d_done      = r_d_done;
    assign d_rdata     = r_d_rdata;
    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule
